mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Sequences 8-bit or 16-bit loads and stores from the pipeline MEM stage onto a
// byte-wide memory port, one byte per cycle, stalling the pipeline until done.
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        byteOp,
  input  logic        signedLoad,
  input  logic [15:0] address,
  input  logic [15:0] writeData,
  output logic        stall,
  output logic        done,
  output logic [15:0] readData,
  output logic        illegal,
  output logic [15:0] bAddr,
  output logic [7:0]  bWdata,
  output logic        bWe,
  output logic        bRe,
  input  logic [7:0]  bRdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RDW,
    WR0,
    WR1,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        byte_q;
  logic        signed_q;
  logic [7:0]  first_q;
  logic [15:0] addr_inc;
  logic [15:0] load_word;
  logic        accept;
  logic        both_req;

  assign both_req = req && memRead && memWrite;
  assign accept   = (state == IDLE) && req && (memRead ^ memWrite);
  // Wraps naturally at 16 bits, so odd word addresses and 16'hFFFF need no special case.
  assign addr_inc = addr_q + 16'd1;

  always_comb begin
    if (byte_q)
      load_word = {(signed_q ? {8{bRdata[7]}} : 8'h00), bRdata};
    else if (BIG_ENDIAN)
      load_word = {first_q, bRdata};
    else
      load_word = {bRdata, first_q};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: operand and byte-capture registers carry no reset; they are always
  // written (on acceptance / in RD1) before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= address;
      wdata_q  <= writeData;
      byte_q   <= byteOp;
      signed_q <= signedLoad;
    end
    if (state == RD1) first_q <= bRdata;
  end

  // readData only changes when a load completes; stores leave it alone.
  always_ff @(posedge clk) begin
    if (reset)              readData <= 16'h0000;
    else if (state == RDW)  readData <= load_word;
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    bRe        = 1'b0;
    bWe        = 1'b0;
    bAddr      = addr_q;
    bWdata     = 8'h00;
    case (state)
      IDLE: begin
        if (both_req) begin
          illegal = 1'b1;
        end else if (accept) begin
          stall      = 1'b1;
          state_next = memRead ? RD0 : (byteOp ? WR1 : WR0);
        end
      end
      RD0: begin
        stall      = 1'b1;
        bRe        = 1'b1;
        state_next = byte_q ? RDW : RD1;
      end
      RD1: begin
        stall      = 1'b1;
        bRe        = 1'b1;
        bAddr      = addr_inc;
        state_next = RDW;
      end
      RDW: begin
        stall      = 1'b1;
        state_next = DONE;
      end
      WR0: begin
        stall      = 1'b1;
        bWe        = 1'b1;
        bWdata     = BIG_ENDIAN ? wdata_q[15:8] : wdata_q[7:0];
        state_next = WR1;
      end
      WR1: begin
        stall = 1'b1;
        bWe   = 1'b1;
        // A byte store skips WR0 and writes its single byte at the base address.
        if (byte_q) begin
          bWdata = wdata_q[7:0];
        end else begin
          bAddr  = addr_inc;
          bWdata = BIG_ENDIAN ? wdata_q[7:0] : wdata_q[15:8];
        end
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // The state register still holds the old state during the reset cycle.
    if (reset) begin
      state_next = IDLE;
      stall      = 1'b0;
      done       = 1'b0;
      illegal    = 1'b0;
      bRe        = 1'b0;
      bWe        = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a big-endian and a little-endian instance
// share stimulus, each with its own byte-memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, req, memRead, memWrite, byteOp, signedLoad;
  logic [15:0] address, writeData;

  logic        stall_be, done_be, illegal_be, bWe_be, bRe_be;
  logic [15:0] readData_be, bAddr_be;
  logic [7:0]  bWdata_be, bRdata_be;
  logic        stall_le, done_le, illegal_le, bWe_le, bRe_le;
  logic [15:0] readData_le, bAddr_le;
  logic [7:0]  bWdata_le, bRdata_le;

  logic [7:0]  mem_be [0:65535];
  logic [7:0]  mem_le [0:65535];

  int n_vec = 0;
  int n_err = 0;
  int excl_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .req(req), .memRead(memRead), .memWrite(memWrite),
    .byteOp(byteOp), .signedLoad(signedLoad), .address(address), .writeData(writeData),
    .stall(stall_be), .done(done_be), .readData(readData_be), .illegal(illegal_be),
    .bAddr(bAddr_be), .bWdata(bWdata_be), .bWe(bWe_be), .bRe(bRe_be), .bRdata(bRdata_be)
  );

  mem_access_unit #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .req(req), .memRead(memRead), .memWrite(memWrite),
    .byteOp(byteOp), .signedLoad(signedLoad), .address(address), .writeData(writeData),
    .stall(stall_le), .done(done_le), .readData(readData_le), .illegal(illegal_le),
    .bAddr(bAddr_le), .bWdata(bWdata_le), .bWe(bWe_le), .bRe(bRe_le), .bRdata(bRdata_le)
  );

  // Byte memories: preloaded with fixed contents while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      mem_be[16'h0010] <= 8'hAB; mem_le[16'h0010] <= 8'hAB;
      mem_be[16'h0011] <= 8'hCD; mem_le[16'h0011] <= 8'hCD;
      mem_be[16'h0020] <= 8'h80; mem_le[16'h0020] <= 8'h80;
      mem_be[16'h0101] <= 8'h5A; mem_le[16'h0101] <= 8'h5A;
      mem_be[16'h0102] <= 8'h3C; mem_le[16'h0102] <= 8'h3C;
    end else begin
      if (bWe_be) mem_be[bAddr_be] <= bWdata_be;
      if (bWe_le) mem_le[bAddr_le] <= bWdata_le;
    end
    if (bRe_be) bRdata_be <= mem_be[bAddr_be];
    if (bRe_le) bRdata_le <= mem_le[bAddr_le];
  end

  always @(negedge clk) begin
    if ((bWe_be && bRe_be) || (bWe_le && bRe_le)) excl_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one access at the current cycle N and follow it to DONE.
  task automatic access(input logic rd, input logic wr, input logic bop, input logic sgn,
                        input logic [15:0] a, input logic [15:0] wd, input int exp_lat,
                        input logic [15:0] exp_be, input logic [15:0] exp_le, input string tag);
    int   lat;
    logic stall_ok;
    req = 1'b1; memRead = rd; memWrite = wr; byteOp = bop; signedLoad = sgn;
    address = a; writeData = wd;
    @(negedge clk);
    check({tag, "_accept_stall"}, {illegal_be, illegal_le, stall_be, stall_le}, 4'b0011);
    @(posedge clk); #1;
    req = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (lat <= 10) begin
      @(negedge clk);
      if (done_be) break;
      stall_ok &= stall_be & stall_le;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_stall"}, stall_ok, 1);
    check({tag, "_done_state"}, {done_le, stall_be, stall_le, bWe_be, bRe_be, bWe_le, bRe_le}, 7'b1000000);
    check({tag, "_rdata_be"}, readData_be, exp_be);
    check({tag, "_rdata_le"}, readData_le, exp_le);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {done_be, done_le}, 2'b00);
  endtask

  initial begin
    logic quiet;
    reset = 1'b1; req = 1'b0; memRead = 1'b0; memWrite = 1'b0; byteOp = 1'b0;
    signedLoad = 1'b0; address = 16'h0000; writeData = 16'h0000;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_outputs",
          {readData_be, readData_le, done_be, done_le, stall_be, stall_le,
           illegal_be, illegal_le, bWe_be, bRe_be, bWe_le, bRe_le}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    access(1, 0, 0, 0, 16'h0010, 16'h0000, 4, 16'hABCD, 16'hCDAB, "word_load");
    access(1, 0, 1, 1, 16'h0020, 16'h0000, 3, 16'hFF80, 16'hFF80, "sbyte_load");
    access(1, 0, 1, 0, 16'h0020, 16'h0000, 3, 16'h0080, 16'h0080, "ubyte_load");
    access(0, 1, 0, 0, 16'hFFFF, 16'h1234, 3, 16'h0080, 16'h0080, "word_store_wrap");
    check("wrap_mem_be", {mem_be[16'hFFFF], mem_be[16'h0000]}, 16'h1234);
    check("wrap_mem_le", {mem_le[16'hFFFF], mem_le[16'h0000]}, 16'h3412);
    access(1, 0, 0, 0, 16'hFFFF, 16'h0000, 4, 16'h1234, 16'h1234, "word_load_wrap");
    access(1, 0, 0, 0, 16'h0101, 16'h0000, 4, 16'h5A3C, 16'h3C5A, "word_load_odd");
    access(0, 1, 1, 0, 16'h0200, 16'h77A5, 2, 16'h5A3C, 16'h3C5A, "byte_store");
    check("byte_store_mem", {mem_be[16'h0200], mem_le[16'h0200]}, 16'hA5A5);
    access(1, 0, 1, 1, 16'h0200, 16'h0000, 3, 16'hFFA5, 16'hFFA5, "sbyte_load_neg");
    access(1, 0, 1, 1, 16'h0101, 16'h0000, 3, 16'h005A, 16'h005A, "sbyte_load_pos");

    // Conflicting request: illegal for one cycle, nothing else.
    req = 1'b1; memRead = 1'b1; memWrite = 1'b1; address = 16'h0010;
    @(negedge clk);
    check("illegal_pulse", {illegal_be, illegal_le, stall_be, stall_le, bWe_be, bRe_be, bWe_le, bRe_le},
          8'b11000000);
    @(posedge clk); #1;
    req = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      quiet &= ~(done_be | done_le | stall_be | stall_le | illegal_be | illegal_le |
                 bWe_be | bRe_be | bWe_le | bRe_le);
      @(posedge clk); #1;
    end
    check("illegal_quiet", quiet, 1);

    // Request with neither read nor write is ignored.
    req = 1'b1;
    @(negedge clk);
    check("noop_req", {stall_be, stall_le, illegal_be, illegal_le}, 4'b0000);
    @(posedge clk); #1;
    req = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      quiet &= ~(done_be | done_le | stall_be | stall_le | bRe_be | bRe_le);
      @(posedge clk); #1;
    end
    check("noop_quiet", quiet, 1);

    // Reset during RD1 of a word load aborts it.
    req = 1'b1; memRead = 1'b1; byteOp = 1'b0; address = 16'h0010;
    @(posedge clk); #1;
    req = 1'b0; memRead = 1'b0;
    @(negedge clk);
    check("abort_rd0", {bRe_be, bAddr_be}, {1'b1, 16'h0010});
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_reset_cycle", {stall_be, stall_le, bRe_be, bRe_le, done_be, done_le}, 6'b000000);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_rdata", {readData_be, readData_le}, 32'h0);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      quiet &= ~(done_be | done_le | stall_be | stall_le | bRe_be | bRe_le | bWe_be | bWe_le);
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("abort_no_done", quiet, 1);
    @(posedge clk); #1;

    access(0, 1, 1, 0, 16'h0300, 16'h00C3, 2, 16'h0000, 16'h0000, "post_reset_store");
    check("post_reset_mem", {mem_be[16'h0300], mem_le[16'h0300]}, 16'hC3C3);
    check("we_re_exclusive", excl_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
